uart_axis_rx: RTL and testbench

// - UART receiver, 8N1, LSB first; converts serial line into byte AXI-stream
//   (o_tdata/o_tvalid/i_tready). Receive-side counterpart of the emitter UART

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_axis_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_axis_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, data width and the
// clocks-per-bit helper used to size the bit-period counter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset, both flops load RST_VAL
//   i_d     - asynchronous input
//   o_q     - synchronised output
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Metastability filter chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_axis_rx.sv
// 8N1 UART receiver (LSB first) presenting bytes on a single-entry
// AXI-stream style output register, with framing-error and overrun pulses.
// Ports:
//   i_clk, i_rst_n        - clock, asynchronous active-low reset
//   i_uart_rx             - serial line, asynchronous, idle high
//   o_tdata/o_tvalid      - received byte and its valid flag
//   i_tready              - consumer accepts byte when o_tvalid & i_tready
//   o_frame_err           - one-cycle pulse, stop bit sampled low
//   o_overrun             - one-cycle pulse, byte dropped because output full
module uart_axis_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 16_000_000,
  parameter int unsigned BAUD_RATE   = 57_600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_axis_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  logic                      w_rx_s;
  uart_state_e               r_state;
  uart_state_e               w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [7:0]                r_tdata;
  logic                      r_tvalid;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_cnt_zero;
  logic w_load_half;
  logic w_load_full;
  logic w_dec;
  logic w_shift;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_deliver;
  logic w_frame_err;
  logic w_drop;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (w_rx_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (!w_rx_s) w_next_state = START;
      START: if (w_cnt_zero) w_next_state = w_rx_s ? IDLE : DATA;
      DATA:  if (w_cnt_zero && (r_idx == IDX_LAST)) w_next_state = STOP;
      STOP:  if (w_cnt_zero) w_next_state = w_rx_s ? IDLE : BREAK;
      // Hold off until the line returns high so a long break is not
      // mistaken for a new start bit.
      BREAK: if (w_rx_s) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath controls decoded from state.
  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_dec       = 1'b0;
    w_shift     = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: w_load_half = !w_rx_s;
      START: begin
        if (!w_cnt_zero) begin
          w_dec = 1'b1;
        end else if (!w_rx_s) begin
          w_load_full = 1'b1;
          w_idx_clr   = 1'b1;
        end
      end
      DATA: begin
        if (!w_cnt_zero) begin
          w_dec = 1'b1;
        end else begin
          w_shift     = 1'b1;
          w_load_full = 1'b1;
          w_idx_inc   = (r_idx != IDX_LAST);
        end
      end
      STOP: begin
        if (!w_cnt_zero) w_dec = 1'b1;
        else if (w_rx_s) w_deliver = 1'b1;
        else             w_frame_err = 1'b1;
      end
      default: ;
    endcase
  end

  // A finished byte is dropped only if the held byte is not leaving this cycle.
  assign w_drop = w_deliver & r_tvalid & ~i_tready;

  // Bit-period counter, bit index and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      if (w_load_half)      r_cnt <= CNT_HALF;
      else if (w_load_full) r_cnt <= CNT_FULL;
      else if (w_dec)       r_cnt <= r_cnt - CNT_W'(1);

      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);

      // LSB arrives first, so shift right and enter at the MSB.
      if (w_shift) r_shreg <= {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
    end
  end

  // Output register and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_drop;
      if (w_deliver && !w_drop) begin
        r_tdata  <= r_shreg;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && i_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_tdata     = r_tdata;
  assign o_tvalid    = r_tvalid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_axis_rx.sv
// Directed self-checking bench for uart_axis_rx at 16 clocks per bit.
// A negedge monitor counts handshakes, status pulses and valid cycles;
// each scenario task drives the line and compares against hand-derived values.
module tb_uart_axis_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       tready;
  logic [7:0] tdata;
  logic       tvalid;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         hs_cnt;
  logic [7:0] hs_data;
  int         fe_cnt;
  int         ov_cnt;
  int         tv_cyc;
  int         tv_low;
  int         rise_cyc;
  logic       tv_prev;

  uart_axis_rx #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_uart_rx   (rx),
    .o_tdata     (tdata),
    .o_tvalid    (tvalid),
    .i_tready    (tready),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tvalid && tready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_data <= tdata;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (tvalid)    tv_cyc <= tv_cyc + 1;
    else           tv_low <= tv_low + 1;
    if (tvalid && !tv_prev && rise_cyc < 0) rise_cyc <= cyc;
    tv_prev <= tvalid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    hs_cnt   = 0;
    hs_data  = 8'h00;
    fe_cnt   = 0;
    ov_cnt   = 0;
    tv_cyc   = 0;
    tv_low   = 0;
    rise_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rx     = 1'b1;
    tready = 1'b0;
    tv_prev = 1'b0;
    clear_mon();
    tick(3);
    checks++; if (tvalid !== 1'b0)   begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00)   begin failures++; $display("FAIL reset_tdata got=%h exp=00", tdata); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    int t0;
    tready = 1'b1;
    clear_mon();
    t0 = cyc;
    send_byte(8'h55, 1'b1);
    tick(20);
    checks++; if (hs_cnt !== 1)       begin failures++; $display("FAIL basic_hs_cnt got=%0d exp=1", hs_cnt); end
    checks++; if (hs_data !== 8'h55)  begin failures++; $display("FAIL basic_data got=%h exp=55", hs_data); end
    checks++; if (tv_cyc !== 1)       begin failures++; $display("FAIL basic_tvalid_cycles got=%0d exp=1", tv_cyc); end
    checks++; if (rise_cyc - t0 !== 155) begin failures++; $display("FAIL basic_latency got=%0d exp=155", rise_cyc - t0); end
    checks++; if (fe_cnt !== 0)       begin failures++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt); end
    checks++; if (ov_cnt !== 0)       begin failures++; $display("FAIL basic_overrun got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_overrun();
    tready = 1'b0;
    clear_mon();
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    tick(10);
    checks++; if (ov_cnt !== 1)       begin failures++; $display("FAIL ovr_pulse_cycles got=%0d exp=1", ov_cnt); end
    checks++; if (tvalid !== 1'b1)    begin failures++; $display("FAIL ovr_tvalid_held got=%b exp=1", tvalid); end
    checks++; if (tdata !== 8'hA3)    begin failures++; $display("FAIL ovr_tdata_held got=%h exp=a3", tdata); end
    checks++; if (hs_cnt !== 0)       begin failures++; $display("FAIL ovr_no_hs got=%0d exp=0", hs_cnt); end
    checks++; if (fe_cnt !== 0)       begin failures++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
    tready = 1'b1;
    tick(1);
    checks++; if (tvalid !== 1'b0)    begin failures++; $display("FAIL ovr_tvalid_drop got=%b exp=0", tvalid); end
    checks++; if (hs_data !== 8'hA3)  begin failures++; $display("FAIL ovr_hs_data got=%h exp=a3", hs_data); end
    tick(5);
  endtask

  task automatic test_frame_err();
    tready = 1'b1;
    clear_mon();
    send_byte(8'hFF, 1'b0);
    tick(20 * CPB);
    rx = 1'b1;
    tick(20);
    checks++; if (fe_cnt !== 1)       begin failures++; $display("FAIL ferr_pulse_cycles got=%0d exp=1", fe_cnt); end
    checks++; if (tv_cyc !== 0)       begin failures++; $display("FAIL ferr_no_tvalid got=%0d exp=0", tv_cyc); end
    checks++; if (ov_cnt !== 0)       begin failures++; $display("FAIL ferr_overrun got=%0d exp=0", ov_cnt); end
    send_byte(8'h12, 1'b1);
    tick(20);
    checks++; if (hs_cnt !== 1)       begin failures++; $display("FAIL ferr_recover_hs got=%0d exp=1", hs_cnt); end
    checks++; if (hs_data !== 8'h12)  begin failures++; $display("FAIL ferr_recover_data got=%h exp=12", hs_data); end
    checks++; if (fe_cnt !== 1)       begin failures++; $display("FAIL ferr_no_extra got=%0d exp=1", fe_cnt); end
  endtask

  task automatic test_glitch();
    tready = 1'b1;
    clear_mon();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    checks++; if (tv_cyc !== 0)       begin failures++; $display("FAIL glitch_tvalid got=%0d exp=0", tv_cyc); end
    checks++; if (fe_cnt !== 0)       begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); end
    checks++; if (ov_cnt !== 0)       begin failures++; $display("FAIL glitch_overrun got=%0d exp=0", ov_cnt); end
    checks++; if (dut.r_state !== uart_pkg::IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.r_state, uart_pkg::IDLE); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    tready = 1'b0;
    send_byte(8'h5A, 1'b1);
    tick(5);
    d = 8'h99;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = d[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0)    begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00)    begin failures++; $display("FAIL rstmid_tdata got=%h exp=00", tdata); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    tready = 1'b1;
    clear_mon();
    send_byte(8'h3C, 1'b1);
    tick(20);
    checks++; if (hs_cnt !== 1)       begin failures++; $display("FAIL rstmid_hs_cnt got=%0d exp=1", hs_cnt); end
    checks++; if (hs_data !== 8'h3C)  begin failures++; $display("FAIL rstmid_data got=%h exp=3c", hs_data); end
    checks++; if (fe_cnt !== 0)       begin failures++; $display("FAIL rstmid_frame_err_cnt got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_back_to_back();
    tready = 1'b0;
    send_byte(8'h7E, 1'b1);
    tick(5);
    checks++; if (tdata !== 8'h7E)    begin failures++; $display("FAIL b2b_first_held got=%h exp=7e", tdata); end
    clear_mon();
    fork
      send_byte(8'h81, 1'b1);
      begin
        tick(154);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
      end
    join
    tick(5);
    checks++; if (tvalid !== 1'b1)    begin failures++; $display("FAIL b2b_tvalid got=%b exp=1", tvalid); end
    checks++; if (tdata !== 8'h81)    begin failures++; $display("FAIL b2b_tdata got=%h exp=81", tdata); end
    checks++; if (hs_cnt !== 1)       begin failures++; $display("FAIL b2b_hs_cnt got=%0d exp=1", hs_cnt); end
    checks++; if (hs_data !== 8'h7E)  begin failures++; $display("FAIL b2b_hs_data got=%h exp=7e", hs_data); end
    checks++; if (ov_cnt !== 0)       begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt); end
    checks++; if (tv_low !== 0)       begin failures++; $display("FAIL b2b_tvalid_gap got=%0d exp=0", tv_low); end
    tready = 1'b1;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
